// File: rtl/rv32_load_store_unit.sv
// rv32_load_store_unit
// Load/store unit between a core-side request port and a synchronous
// single-port RAM. An access that stays inside one RAM word takes one RAM
// beat. When SPLIT_EN=1, an access that crosses a word boundary takes two
// beats. When SPLIT_EN=0, that access returns an error instead.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   req_valid/ready    request handshake; ready is high only in IDLE
//   req_we             1 = store, 0 = load
//   req_width          0 byte, 1 half, 2 word, 3 double
//   req_sign           sign-extend the load result
//   req_addr           byte address
//   req_wdata          right-justified store data
//   rsp_valid          one-cycle response pulse
//   rsp_rdata          extended load data (0 for stores and errors)
//   rsp_err            error flag, qualified by rsp_valid
//   d_addr             word-aligned RAM address
//   d_we, d_be         RAM write enable and byte enables
//   d_wdata            store data rotated into its byte lanes
//   d_rdata            RAM read data, valid one cycle after its address
`timescale 1ns/1ps

module rv32_load_store_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_width,
    input  logic                  req_sign,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_W-1:0]     d_addr,
    output logic                  d_we,
    output logic [DATA_W/8-1:0]   d_be,
    output logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W-1:0]     d_rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;

    // Request fields held for the life of the transaction
    logic                we_r;
    logic [1:0]          width_r;
    logic                sign_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   beat0_r;

    // Fields of the current transaction: live inputs in IDLE, held copy after
    logic                we_s;
    logic [1:0]          width_s;
    logic                sign_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [DATA_W-1:0]   wdata_s;

    logic [OFF_W-1:0]    off_s;
    logic [4:0]          sz_s;
    logic                misalign_s;
    logic                err_s;
    logic                split_s;
    logic [ADDR_W-1:0]   aligned_s;
    logic [2*NB-1:0]     be_full_s;
    logic [NB-1:0]       be_lo_s;
    logic [NB-1:0]       be_hi_s;
    logic [DATA_W-1:0]   rot_s;

    logic [ADDR_W-1:0]   d_addr_next_s;
    logic                d_we_next_s;
    logic [NB-1:0]       d_be_next_s;
    logic [DATA_W-1:0]   d_wdata_next_s;
    logic                rsp_valid_next_s;
    logic                rsp_err_next_s;

    logic [DATA_W-1:0]   beat0_sel_s;
    logic [2*DATA_W-1:0] load_pair_s;
    logic [DATA_W-1:0]   load_raw_s;
    logic [DATA_W-1:0]   load_ext_s;
    logic                sign_bit_s;
    logic                fill_s;

    // Expands byte enables to a bit mask
    function automatic logic [DATA_W-1:0] be_to_mask(input logic [NB-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    assign req_ready = (state_r == IDLE);

    // Pick live request inputs while idle so outputs can be registered on acceptance
    always_comb begin
        if (state_r == IDLE) begin
            we_s    = req_we;
            width_s = req_width;
            sign_s  = req_sign;
            addr_s  = req_addr;
            wdata_s = req_wdata;
        end else begin
            we_s    = we_r;
            width_s = width_r;
            sign_s  = sign_r;
            addr_s  = addr_r;
            wdata_s = wdata_r;
        end
    end

    // Offset, size, and the misaligned or error classification
    always_comb begin
        off_s      = addr_s[OFF_W-1:0];
        sz_s       = 5'd1 << width_s;
        misalign_s = (5'(off_s) + sz_s) > 5'(NB);
        err_s      = ((width_s == 2'd3) && (DATA_W == 32)) ||
                     ((SPLIT_EN == 0) && misalign_s);
        split_s    = misalign_s && !err_s;
        aligned_s  = {addr_s[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Byte enables across two beats; bits above NB are the overflow lanes
    always_comb begin
        be_full_s = '0;
        for (int i = 0; i < 2*NB; i++) begin
            if ((i >= int'(off_s)) && (i < int'(off_s) + int'(sz_s))) begin
                be_full_s[i] = 1'b1;
            end else begin
                be_full_s[i] = 1'b0;
            end
        end
        be_lo_s = be_full_s[NB-1:0];
        be_hi_s = be_full_s[2*NB-1:NB];
    end

    // Rotate store data left by the byte offset, then mask to the active lanes per beat
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < NB; i++) begin
            rot_s[8*((i + int'(off_s)) % NB) +: 8] = wdata_s[8*i +: 8];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_next_s = ACC0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACC0: begin
                if (split_s) begin
                    state_next_s = ACC1;
                end else begin
                    state_next_s = RESP;
                end
            end
            ACC1:    state_next_s = RESP;
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Next output values, decoded from the state being entered so the outputs are registered
    always_comb begin
        d_addr_next_s    = '0;
        d_we_next_s      = 1'b0;
        d_be_next_s      = '0;
        d_wdata_next_s   = '0;
        rsp_valid_next_s = 1'b0;
        rsp_err_next_s   = 1'b0;
        case (state_next_s)
            ACC0: begin
                if (!err_s) begin
                    d_addr_next_s  = aligned_s;
                    d_we_next_s    = we_s;
                    d_be_next_s    = be_lo_s;
                    d_wdata_next_s = rot_s & be_to_mask(be_lo_s);
                end else begin
                    d_addr_next_s  = '0;
                    d_we_next_s    = 1'b0;
                    d_be_next_s    = '0;
                    d_wdata_next_s = '0;
                end
            end
            ACC1: begin
                d_addr_next_s  = aligned_s + ADDR_W'(NB);
                d_we_next_s    = we_s;
                d_be_next_s    = be_hi_s;
                d_wdata_next_s = rot_s & be_to_mask(be_hi_s);
            end
            RESP: begin
                rsp_valid_next_s = 1'b1;
                rsp_err_next_s   = err_s;
            end
            default: begin
                rsp_valid_next_s = 1'b0;
            end
        endcase
    end

    // Registered RAM-side and response-flag outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_addr    <= '0;
            d_we      <= 1'b0;
            d_be      <= '0;
            d_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            d_addr    <= d_addr_next_s;
            d_we      <= d_we_next_s;
            d_be      <= d_be_next_s;
            d_wdata   <= d_wdata_next_s;
            rsp_valid <= rsp_valid_next_s;
            rsp_err   <= rsp_err_next_s;
        end
    end

    // Capture request fields on acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_r    <= 1'b0;
            width_r <= 2'd0;
            sign_r  <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if ((state_r == IDLE) && req_valid) begin
            we_r    <= req_we;
            width_r <= req_width;
            sign_r  <= req_sign;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end
    end

    // The beat-0 read data arrives during ACC1 of a split load; hold it for the merge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat0_r <= '0;
        end else if (state_r == ACC1) begin
            beat0_r <= d_rdata;
        end
    end

    // Load extraction and extension. The data reaches RESP straight from the RAM,
    // so this path is combinational to avoid adding a cycle of latency.
    always_comb begin
        if (split_s) begin
            beat0_sel_s = beat0_r;
        end else begin
            beat0_sel_s = d_rdata;
        end
        load_pair_s = {d_rdata, beat0_sel_s};
        load_raw_s  = '0;
        for (int i = 0; i < NB; i++) begin
            load_raw_s[8*i +: 8] = load_pair_s[8*(i + int'(off_s)) +: 8];
        end
        case (width_s)
            2'd0:    sign_bit_s = load_raw_s[7];
            2'd1:    sign_bit_s = load_raw_s[15];
            2'd2:    sign_bit_s = load_raw_s[31];
            default: sign_bit_s = load_raw_s[DATA_W-1];
        endcase
        fill_s     = sign_s & sign_bit_s;
        load_ext_s = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(sz_s)) begin
                load_ext_s[8*i +: 8] = load_raw_s[8*i +: 8];
            end else begin
                load_ext_s[8*i +: 8] = {8{fill_s}};
            end
        end
        if ((state_r == RESP) && !we_s && !err_s) begin
            rsp_rdata = load_ext_s;
        end else begin
            rsp_rdata = '0;
        end
    end

endmodule

// File: tb/tb_rv32_load_store_unit.sv
`timescale 1ns/1ps

module tb_rv32_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_valid_ns;
    logic        req_we, req_sign;
    logic [1:0]  req_width;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, rsp_valid, rsp_err, d_we;
    logic [31:0] rsp_rdata, d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;

    logic        req_ready_ns, rsp_valid_ns, rsp_err_ns, d_we_ns;
    logic [31:0] rsp_rdata_ns, d_addr_ns, d_wdata_ns, d_rdata_ns;
    logic [3:0]  d_be_ns;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-cycle trace after acceptance; index k is the cycle ending at edge T+k
    logic [31:0] t_addr [1:6];
    logic [3:0]  t_be   [1:6];
    logic        t_we   [1:6];
    logic [31:0] t_wdata[1:6];
    logic        t_valid[1:6];
    logic        t_err  [1:6];
    logic [31:0] t_rdata[1:6];
    logic        t_ready[1:6];

    bit [7:0] mem [256];

    always #5 clk = ~clk;

    assign d_rdata_ns = 32'h0;

    rv32_load_store_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_width(req_width), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .d_addr(d_addr), .d_we(d_we), .d_be(d_be),
        .d_wdata(d_wdata), .d_rdata(d_rdata)
    );

    rv32_load_store_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(0)) dut_ns (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid_ns), .req_ready(req_ready_ns), .req_we(req_we),
        .req_width(req_width), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid_ns), .rsp_rdata(rsp_rdata_ns),
        .rsp_err(rsp_err_ns), .d_addr(d_addr_ns), .d_we(d_we_ns), .d_be(d_be_ns),
        .d_wdata(d_wdata_ns), .d_rdata(d_rdata_ns)
    );

    // Synchronous byte-enabled RAM, read data one cycle after the address
    always @(posedge clk) begin
        if (d_we) begin
            for (int i = 0; i < 4; i++) begin
                if (d_be[i]) mem[8'(d_addr[7:0] + 8'(i))] <= d_wdata[8*i +: 8];
            end
        end
        d_rdata <= {mem[8'(d_addr[7:0] + 8'd3)], mem[8'(d_addr[7:0] + 8'd2)],
                    mem[8'(d_addr[7:0] + 8'd1)], mem[d_addr[7:0]]};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request on either instance and record ncyc cycles after acceptance
    task automatic run(input bit ns, input bit we, input logic [1:0] width, input bit sign,
                       input logic [31:0] addr, input logic [31:0] wdata, input int ncyc);
        int guard = 0;
        @(negedge clk);
        while (!(ns ? req_ready_ns : req_ready) && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {63'd0, (ns ? req_ready_ns : req_ready)}, 64'd1);
        req_we = we; req_width = width; req_sign = sign; req_addr = addr; req_wdata = wdata;
        if (ns) req_valid_ns = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_valid_ns = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            t_addr[k]  = ns ? d_addr_ns    : d_addr;
            t_be[k]    = ns ? d_be_ns      : d_be;
            t_we[k]    = ns ? d_we_ns      : d_we;
            t_wdata[k] = ns ? d_wdata_ns   : d_wdata;
            t_valid[k] = ns ? rsp_valid_ns : rsp_valid;
            t_err[k]   = ns ? rsp_err_ns   : rsp_err;
            t_rdata[k] = ns ? rsp_rdata_ns : rsp_rdata;
            t_ready[k] = ns ? req_ready_ns : req_ready;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; req_valid_ns = 1'b0;
        req_we = 1'b0; req_sign = 1'b0; req_width = 2'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready",  {63'd0, req_ready}, 64'd1);
        check("rst_valid",  {63'd0, rsp_valid}, 64'd0);
        check("rst_err",    {63'd0, rsp_err},   64'd0);
        check("rst_we",     {63'd0, d_we},      64'd0);
        check("rst_be",     {60'd0, d_be},      64'd0);
        check("rst_addr",   {32'd0, d_addr},    64'd0);
        check("rst_wdata",  {32'd0, d_wdata},   64'd0);
        check("rst_rdata",  {32'd0, rsp_rdata}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Byte store 0x1191 @0x51
        run(1'b0, 1'b1, 2'd0, 1'b0, 32'h51, 32'h1191, 3);
        check("sb_addr",   {32'd0, t_addr[1]},  64'h50);
        check("sb_be",     {60'd0, t_be[1]},    64'h2);
        check("sb_wdata",  {32'd0, t_wdata[1]}, 64'h9100);
        check("sb_we0",    {63'd0, t_we[1]},    64'd1);
        check("sb_we1",    {63'd0, t_we[2]},    64'd0);
        check("sb_val1",   {63'd0, t_valid[1]}, 64'd0);
        check("sb_val2",   {63'd0, t_valid[2]}, 64'd1);
        check("sb_err",    {63'd0, t_err[2]},   64'd0);
        check("sb_val3",   {63'd0, t_valid[3]}, 64'd0);

        // Half store 0xFFFB @0x52, then signed and unsigned half loads
        run(1'b0, 1'b1, 2'd1, 1'b0, 32'h52, 32'hFFFB, 3);
        check("sh_be",     {60'd0, t_be[1]},    64'hC);
        check("sh_wdata",  {32'd0, t_wdata[1]}, 64'hFFFB0000);
        run(1'b0, 1'b0, 2'd1, 1'b1, 32'h52, 32'h0, 3);
        check("lh_val",    {63'd0, t_valid[2]}, 64'd1);
        check("lh_rdata",  {32'd0, t_rdata[2]}, 64'hFFFFFFFB);
        check("lh_we",     {63'd0, t_we[1]},    64'd0);
        run(1'b0, 1'b0, 2'd1, 1'b0, 32'h52, 32'h0, 3);
        check("lhu_rdata", {32'd0, t_rdata[2]}, 64'h0000FFFB);
        run(1'b0, 1'b0, 2'd0, 1'b1, 32'h51, 32'h0, 3);
        check("lb_rdata",  {32'd0, t_rdata[2]}, 64'hFFFFFF91);

        // Split word store 0x12345678 @0x0E, then split word load
        run(1'b0, 1'b1, 2'd2, 1'b0, 32'h0E, 32'h12345678, 4);
        check("sw0_addr",  {32'd0, t_addr[1]},  64'h0C);
        check("sw0_be",    {60'd0, t_be[1]},    64'hC);
        check("sw0_wdata", {32'd0, t_wdata[1]}, 64'h56780000);
        check("sw0_we",    {63'd0, t_we[1]},    64'd1);
        check("sw1_addr",  {32'd0, t_addr[2]},  64'h10);
        check("sw1_be",    {60'd0, t_be[2]},    64'h3);
        check("sw1_wdata", {32'd0, t_wdata[2]}, 64'h1234);
        check("sw1_we",    {63'd0, t_we[2]},    64'd1);
        check("sw_val2",   {63'd0, t_valid[2]}, 64'd0);
        check("sw_val3",   {63'd0, t_valid[3]}, 64'd1);
        check("sw_resp_be",{60'd0, t_be[3]},    64'd0);
        run(1'b0, 1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, 4);
        check("lw_val2",   {63'd0, t_valid[2]}, 64'd0);
        check("lw_val3",   {63'd0, t_valid[3]}, 64'd1);
        check("lw_rdata",  {32'd0, t_rdata[3]}, 64'h12345678);
        check("lw_err",    {63'd0, t_err[3]},   64'd0);

        // Misaligned word load on the non-splitting instance
        run(1'b1, 1'b0, 2'd2, 1'b0, 32'h0D, 32'h0, 3);
        check("ns_we1",    {63'd0, t_we[1]},    64'd0);
        check("ns_be1",    {60'd0, t_be[1]},    64'd0);
        check("ns_be2",    {60'd0, t_be[2]},    64'd0);
        check("ns_val2",   {63'd0, t_valid[2]}, 64'd1);
        check("ns_err2",   {63'd0, t_err[2]},   64'd1);
        check("ns_rdata2", {32'd0, t_rdata[2]}, 64'd0);

        // Double width on a 32-bit RAM
        run(1'b0, 1'b0, 2'd3, 1'b0, 32'h50, 32'h0, 3);
        check("dw_be1",    {60'd0, t_be[1]},    64'd0);
        check("dw_val2",   {63'd0, t_valid[2]}, 64'd1);
        check("dw_err2",   {63'd0, t_err[2]},   64'd1);
        check("dw_rdata2", {32'd0, t_rdata[2]}, 64'd0);

        // Reset during ACC1 of a split store
        @(negedge clk);
        req_we = 1'b1; req_width = 2'd2; req_sign = 1'b0;
        req_addr = 32'h0E; req_wdata = 32'hAABBCCDD; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rm_acc1_we", {63'd0, d_we}, 64'd1);
        check("rm_acc1_be", {60'd0, d_be}, 64'h3);
        reset_n = 1'b0;
        #1;
        check("rm_we",     {63'd0, d_we},      64'd0);
        check("rm_be",     {60'd0, d_be},      64'd0);
        check("rm_val",    {63'd0, rsp_valid}, 64'd0);
        @(negedge clk);
        check("rm_ready",  {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rm_noresp", {63'd0, rsp_valid}, 64'd0);
        end
        run(1'b0, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 3);
        check("rm_val2",   {63'd0, t_valid[2]}, 64'd1);
        check("rm_beat0",  {32'd0, t_rdata[2]}, 64'hCCDD0000);
        run(1'b0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3);
        check("rm_beat1",  {32'd0, t_rdata[2]}, 64'h00001234);

        // Two aligned loads with req_valid held high
        @(negedge clk);
        req_we = 1'b0; req_width = 2'd2; req_sign = 1'b0; req_addr = 32'h50; req_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            t_valid[k] = rsp_valid;
            t_ready[k] = req_ready;
            t_rdata[k] = rsp_rdata;
        end
        req_valid = 1'b0;
        check("bb_val1", {63'd0, t_valid[1]}, 64'd0);
        check("bb_val2", {63'd0, t_valid[2]}, 64'd1);
        check("bb_val3", {63'd0, t_valid[3]}, 64'd0);
        check("bb_val4", {63'd0, t_valid[4]}, 64'd0);
        check("bb_val5", {63'd0, t_valid[5]}, 64'd1);
        check("bb_val6", {63'd0, t_valid[6]}, 64'd0);
        check("bb_rdy2", {63'd0, t_ready[2]}, 64'd0);
        check("bb_rdy3", {63'd0, t_ready[3]}, 64'd1);
        check("bb_rdy4", {63'd0, t_ready[4]}, 64'd0);
        check("bb_rd2",  {32'd0, t_rdata[2]}, 64'hFFFB9100);
        check("bb_rd5",  {32'd0, t_rdata[5]}, 64'hFFFB9100);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
